adder_result_fifo: RTL and testbench

Downstream stage of the 32-bit registered adder. Captures each valid sum from the adder's out port into a small in-order FIFO and presents it to the consumer over a valid/ready handshake. Absorbs consumer back-pressure, which the adder cannot stall for. Counts results dropped while the FIFO is full.

---
 rtl/adder_result_fifo.sv | 85 ++++++++
 tb/tb_adder_result_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// In-order result FIFO behind the 32-bit registered adder, with drop counting on overflow.
// Optional same-cycle fall-through when empty is enabled by defining ADDER_RESULT_FIFO_BYPASS_EN.
module adder_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [15:0]      drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic [15:0]      drop_q;

    logic pop;
    logic push;
    logic drop;
    logic bypass;

    assign count    = count_q;
    assign drop_cnt = drop_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);

`ifdef ADDER_RESULT_FIFO_BYPASS_EN
    // An arriving result that the consumer takes immediately never touches storage.
    assign bypass    = empty && in_valid && out_ready;
    assign out_valid = !empty || in_valid;
    assign out_data  = !empty ? mem[rd_ptr] : (in_valid ? in_data : '0);
`else
    assign bypass    = 1'b0;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
`endif

    assign pop  = !empty && out_ready;
    assign push = in_valid && !bypass && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed, table-driven bench for adder_result_fifo at the default WIDTH=32, DEPTH=4.
module tb_adder_result_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] drop_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  ec;
        logic [15:0] edrop;
    } vec_t;

    vec_t vecs[$];

    adder_result_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .full(full),
        .empty(empty),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic iv, logic [31:0] d, logic rdy,
                                logic ev, logic [31:0] ed, logic [2:0] ec, logic [15:0] edrop);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ec = ec; v.edrop = edrop;
        return v;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic rdy);
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [31:0] ed,
                               input logic [2:0] ec, input logic [15:0] edrop);
        logic ef;
        logic ee;
        ef = (ec == 3'd4);
        ee = (ec == 3'd0);
        testsRun++;
        if (out_valid !== ev || out_data !== ed || count !== ec || full !== ef ||
            empty !== ee || drop_cnt !== edrop) begin
            testsFailed++;
            $display("[TB] FAIL %s: got valid=%b data=%h count=%0d full=%b empty=%b drop=%0d, want valid=%b data=%h count=%0d full=%b empty=%b drop=%0d",
                     name, out_valid, out_data, count, full, empty, drop_cnt,
                     ev, ed, ec, ef, ee, edrop);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
`ifdef ADDER_RESULT_FIFO_BYPASS_EN
        vecs.push_back(mk(1, 32'h786, 1, 1, 32'h786, 0, 0));
        vecs.push_back(mk(1, 32'h5,   0, 1, 32'h5,   0, 0));
        vecs.push_back(mk(0, 0,       0, 1, 32'h5,   1, 0));
        vecs.push_back(mk(0, 0,       1, 1, 32'h5,   1, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0,       0, 0));
`else
        // Single result through, then fill to full, overflow once, pop+push when full, drain.
        vecs.push_back(mk(1, 32'h786, 1, 0, 0,       0, 0));
        vecs.push_back(mk(0, 0,       1, 1, 32'h786, 1, 0));
        vecs.push_back(mk(1, 32'd1,   0, 0, 0,       0, 0));
        vecs.push_back(mk(1, 32'd2,   0, 1, 32'd1,   1, 0));
        vecs.push_back(mk(1, 32'd3,   0, 1, 32'd1,   2, 0));
        vecs.push_back(mk(1, 32'd4,   0, 1, 32'd1,   3, 0));
        vecs.push_back(mk(1, 32'd5,   0, 1, 32'd1,   4, 0));
        vecs.push_back(mk(0, 0,       0, 1, 32'd1,   4, 1));
        vecs.push_back(mk(1, 32'd5,   1, 1, 32'd1,   4, 1));
        vecs.push_back(mk(0, 0,       1, 1, 32'd2,   4, 1));
        vecs.push_back(mk(0, 0,       1, 1, 32'd3,   3, 1));
        vecs.push_back(mk(0, 0,       1, 1, 32'd4,   2, 1));
        vecs.push_back(mk(0, 0,       1, 1, 32'd5,   1, 1));
        vecs.push_back(mk(0, 0,       0, 0, 0,       0, 1));
        // Streaming 0..9 with the consumer always ready wraps the pointers.
        for (int k = 0; k < 10; k++) begin
            if (k == 0) vecs.push_back(mk(1, 32'(k), 1, 0, 0, 0, 1));
            else        vecs.push_back(mk(1, 32'(k), 1, 1, 32'(k - 1), 1, 1));
        end
        vecs.push_back(mk(0, 0, 1, 1, 32'd9, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0, 1));
`endif

        applyStimulus(1, 32'hDEAD, 1);
        step();
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("reset_state", 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].edrop);
            step();
        end

        // Reset mid-operation with a push pending discards everything.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 32'hA0 + 32'(k), 0);
            step();
        end
        rst = 1'b1;
        applyStimulus(1, 32'hDEAD, 1);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("midreset_cleared", 0, 0, 0, 0);
        applyStimulus(1, 32'hABC, 0);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("push_after_reset", 1, 32'hABC, 1, 0);
        applyStimulus(0, 0, 1);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("drain_after_reset", 0, 0, 0, 0);

        // Arrival while empty and consumer ready.
        applyStimulus(1, 32'h331, 1);
`ifdef ADDER_RESULT_FIFO_BYPASS_EN
        checkOutput("empty_arrival_same_cycle", 1, 32'h331, 0, 0);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("empty_arrival_next_cycle", 0, 0, 0, 0);
`else
        checkOutput("empty_arrival_same_cycle", 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0);
        checkOutput("empty_arrival_next_cycle", 1, 32'h331, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
